// File: rtl/axi4_slave_mem.sv
// axi4_slave_mem: AXI4 INCR-burst slave over a 32-bit word memory with independent read/write FSMs.
// Define AXI_SLV_RANGE_CHK_EN to turn beats beyond MEM_WORDS into SLVERR instead of wrapping.
module axi4_slave_mem #(
  parameter int ID_WIDTH   = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORDS  = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);
  localparam int PW = ADDR_WIDTH - 1;
  localparam int LW = $clog2(MEM_WORDS);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  w_state_t            r_wstate, w_wnext;
  r_state_t            r_rstate, w_rnext;
  logic [ID_WIDTH-1:0] r_wid, r_rid;
  logic [PW-1:0]       r_wptr, r_rptr, w_rptr;
  logic [7:0]          r_wrem, r_rrem;
  logic                r_werr, r_rlast;
  logic [31:0]         r_rdata;
  logic [1:0]          r_rresp;
  logic [31:0]         r_mem [MEM_WORDS];
  logic                w_aw_hs, w_w_hs, w_ar_hs, w_r_hs, w_rload, w_woob, w_roob, w_unused;
  assign s_axi_awready = rst_ni && r_wstate == W_IDLE;
  assign s_axi_wready  = r_wstate == W_DATA;
  assign s_axi_bvalid  = r_wstate == W_RESP;
  assign s_axi_bid     = r_wid;
  assign s_axi_bresp   = {r_werr, 1'b0};
  assign s_axi_arready = rst_ni && r_rstate == R_IDLE;
  assign s_axi_rvalid  = r_rstate == R_DATA;
  assign s_axi_rid     = r_rid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rlast   = r_rlast;
  assign w_aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_w_hs  = s_axi_wvalid && s_axi_wready;
  assign w_ar_hs = s_axi_arvalid && s_axi_arready;
  assign w_r_hs  = s_axi_rvalid && s_axi_rready;
  assign w_rload = w_ar_hs || (w_r_hs && !r_rlast);
  assign w_rptr  = w_ar_hs ? PW'(s_axi_araddr[ADDR_WIDTH-1:2]) : r_rptr + PW'(1);
  assign w_unused = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};
  // pointers keep one spare bit so the unwrapped word index stays visible
`ifdef AXI_SLV_RANGE_CHK_EN
  assign w_woob = r_wptr >= PW'(MEM_WORDS);
  assign w_roob = w_rptr >= PW'(MEM_WORDS);
`else
  assign w_woob = 1'b0;
  assign w_roob = 1'b0;
`endif
  always_comb begin
    w_wnext = r_wstate == W_IDLE ? (w_aw_hs ? W_DATA : W_IDLE)
            : r_wstate == W_DATA ? (w_w_hs && r_wrem == 8'd0 ? W_RESP : W_DATA)
            : (s_axi_bready ? W_IDLE : W_RESP);
    w_rnext = r_rstate == R_IDLE ? (w_ar_hs ? R_DATA : R_IDLE)
            : (w_r_hs && r_rlast ? R_IDLE : R_DATA);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wstate <= W_IDLE;
      r_wid    <= '0;
      r_wptr   <= '0;
      r_wrem   <= '0;
      r_werr   <= 1'b0;
    end else begin
      r_wstate <= w_wnext;
      if (w_aw_hs) begin
        r_wid  <= s_axi_awid;
        r_wptr <= PW'(s_axi_awaddr[ADDR_WIDTH-1:2]);
        r_wrem <= s_axi_awlen;
        r_werr <= 1'b0;
      end else if (w_w_hs) begin
        r_wptr <= r_wptr + PW'(1);
        r_wrem <= r_wrem - 8'd1;
        r_werr <= r_werr || w_woob || (s_axi_wlast != (r_wrem == 8'd0));
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (w_w_hs && !w_woob)
      for (int i = 0; i < 4; i++)
        if (s_axi_wstrb[i]) r_mem[r_wptr[LW-1:0]][8*i +: 8] <= s_axi_wdata[8*i +: 8];
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rstate <= R_IDLE;
      r_rid    <= '0;
      r_rptr   <= '0;
      r_rrem   <= '0;
      r_rdata  <= '0;
      r_rresp  <= '0;
      r_rlast  <= 1'b0;
    end else begin
      r_rstate <= w_rnext;
      if (w_ar_hs) begin
        r_rid   <= s_axi_arid;
        r_rrem  <= s_axi_arlen;
        r_rlast <= s_axi_arlen == 8'd0;
      end else if (w_r_hs) begin
        r_rrem  <= r_rrem - 8'd1;
        r_rlast <= r_rrem == 8'd1;
      end
      if (w_rload) begin
        r_rptr  <= w_rptr;
        r_rdata <= w_roob ? 32'd0 : r_mem[w_rptr[LW-1:0]];
        r_rresp <= {w_roob, 1'b0};
      end
    end
  end
endmodule

// File: tb/tb_axi4_slave_mem.sv
// tb_axi4_slave_mem: randomized AXI4 master with array memory model and queue scoreboard.
module tb_axi4_slave_mem;
  localparam int IW = 2;
  localparam int MW = 256;
`ifdef AXI_SLV_RANGE_CHK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif
  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic [IW-1:0] s_axi_awid = '0, s_axi_bid, s_axi_arid = '0, s_axi_rid;
  logic [31:0] s_axi_awaddr = '0, s_axi_araddr = '0, s_axi_wdata = '0, s_axi_rdata;
  logic [7:0] s_axi_awlen = '0, s_axi_arlen = '0;
  logic [3:0] s_axi_wstrb = '0;
  logic [1:0] s_axi_bresp, s_axi_rresp;
  logic s_axi_awvalid = 1'b0, s_axi_awready, s_axi_wlast = 1'b0, s_axi_wvalid = 1'b0, s_axi_wready;
  logic s_axi_bvalid, s_axi_bready = 1'b1, s_axi_arvalid = 1'b0, s_axi_arready;
  logic s_axi_rlast, s_axi_rvalid, s_axi_rready = 1'b0;
  axi4_slave_mem #(.ID_WIDTH(IW), .ADDR_WIDTH(32), .MEM_WORDS(MW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );
  always #5 clk_i = ~clk_i;
  int total = 0, bad = 0;
  logic [31:0] mm [MW];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  logic [IW+1:0]  bq [$];
  logic [IW+34:0] rq [$];
  logic [IW+34:0] snap, e;
  logic st = 1'b0, rand_b = 1'b0;
  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction
  initial forever begin
    @(posedge clk_i); #1;
    s_axi_bready = rand_b ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  // scoreboard monitor: pops an expectation on every B/R handshake, checks R hold during stalls
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (st) chk("r_hold", {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast}, snap);
      if (s_axi_bvalid && s_axi_bready) begin
        chk("b_expected", bq.size() != 0, 1);
        if (bq.size() != 0) begin
          e = {33'd0, bq.pop_front()};
          chk("bid", s_axi_bid, e[IW+1:2]);
          chk("bresp", s_axi_bresp, e[1:0]);
        end
      end
      if (s_axi_rvalid && s_axi_rready) begin
        chk("r_expected", rq.size() != 0, 1);
        if (rq.size() != 0) begin
          e = rq.pop_front();
          chk("rid", s_axi_rid, e[IW+34:35]);
          chk("rdata", s_axi_rdata, e[34:3]);
          chk("rresp", s_axi_rresp, e[2:1]);
          chk("rlast", s_axi_rlast, e[0]);
        end
      end
    end
    st = rst_ni && s_axi_rvalid && !s_axi_rready;
    snap = {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast};
  end
  task automatic wr(input logic [IW-1:0] id, input int addr, input int len, input int lastpos,
                    input bit gaps, input int stop);
    int p, n;
    bit err;
    err = 0;
    for (int b = 0; b <= len && b != stop; b++) begin
      p = addr / 4 + b;
      if ((b == lastpos) != (b == len)) err = 1;
      if (RC && p >= MW) err = 1;
      else for (int i = 0; i < 4; i++) if (ws[b][i]) mm[p % MW][8*i +: 8] = wd[b][8*i +: 8];
    end
    if (stop < 0) bq.push_back({id, err ? 2'b10 : 2'b00});
    @(posedge clk_i); #1;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = 8'(len); s_axi_awvalid = 1'b1;
    n = 0;
    @(negedge clk_i);
    while (!s_axi_awready && n < 50) begin @(negedge clk_i); n++; end
    chk("aw_timeout", n >= 50, 0);
    @(posedge clk_i); #1;
    s_axi_awvalid = 1'b0;
    for (int b = 0; b <= len && b != stop; b++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
      s_axi_wdata = wd[b]; s_axi_wstrb = ws[b]; s_axi_wlast = (b == lastpos); s_axi_wvalid = 1'b1;
      n = 0;
      @(negedge clk_i);
      while (!s_axi_wready && n < 50) begin @(negedge clk_i); n++; end
      chk("w_timeout", n >= 50, 0);
      @(posedge clk_i); #1;
      s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    end
    if (stop >= 0) begin
      #2 rst_ni = 1'b0;
      @(negedge clk_i);
      chk("rst_outputs", {s_axi_awready, s_axi_wready, s_axi_bid, s_axi_bresp, s_axi_bvalid, s_axi_arready,
                          s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid}, 0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      @(negedge clk_i);
      chk("awready_after_rst", s_axi_awready, 1);
      repeat (5) begin
        chk("no_bvalid_after_rst", s_axi_bvalid, 0);
        @(negedge clk_i);
      end
    end else begin
      @(negedge clk_i);
      chk("bvalid_latency", s_axi_bvalid, 1);
      n = 0;
      while (bq.size() != 0 && n < 50) begin @(negedge clk_i); n++; end
      chk("b_timeout", n >= 50, 0);
    end
  endtask
  task automatic rd(input logic [IW-1:0] id, input int addr, input int len, input int stall_at, input bit rnd);
    int p, n, k;
    bit oob;
    for (int b = 0; b <= len; b++) begin
      p = addr / 4 + b;
      oob = RC && p >= MW;
      rq.push_back({id, oob ? 32'd0 : mm[p % MW], oob ? 2'b10 : 2'b00, 1'(b == len)});
    end
    @(posedge clk_i); #1;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = 8'(len); s_axi_arvalid = 1'b1;
    n = 0;
    @(negedge clk_i);
    while (!s_axi_arready && n < 50) begin @(negedge clk_i); n++; end
    chk("ar_timeout", n >= 50, 0);
    @(posedge clk_i); #1;
    s_axi_arvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      k = (b == stall_at) ? 3 : (rnd ? int'($urandom_range(0, 2)) : 0);
      s_axi_rready = (k == 0);
      n = 0;
      @(negedge clk_i);
      while (!s_axi_rvalid && n < 50) begin @(negedge clk_i); n++; end
      chk("r_timeout", n >= 50, 0);
      if (k > 0) begin
        repeat (k) begin @(posedge clk_i); #1; end
        s_axi_rready = 1'b1;
      end
      @(posedge clk_i); #1;
    end
    s_axi_rready = 1'b0;
    @(negedge clk_i);
    chk("r_left", rq.size(), 0);
  endtask
  initial begin
    int len, lp;
    repeat (3) @(negedge clk_i);
    chk("reset_outputs", {s_axi_awready, s_axi_wready, s_axi_bid, s_axi_bresp, s_axi_bvalid, s_axi_arready,
                          s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid}, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    for (int b = 0; b < 256; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
    wr(0, 0, 255, 255, 0, -1);
    for (int b = 0; b < 4; b++) begin wd[b] = 32'(b + 1); ws[b] = 4'hF; end
    wr(1, 'h10, 3, 3, 0, -1);
    rd(2, 'h10, 3, -1, 0);
    rd(2, 'h10, 3, 1, 0);
    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
    wr(1, 'h20, 0, 0, 0, -1);
    wd[0] = 32'hABCD_1234; ws[0] = 4'b0011;
    wr(1, 'h20, 0, 0, 0, -1);
    rd(3, 'h20, 0, -1, 0);
    for (int b = 0; b < 3; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
    wr(2, 'h30, 2, 1, 0, -1);
    wr(3, 'h30, 2, 99, 0, -1);
    rd(0, 'h30, 2, -1, 0);
    wd[0] = 32'h1111_2222; wd[1] = 32'h5555_AAAA; ws[0] = 4'hF; ws[1] = 4'hF;
    wr(0, 'h3FC, 1, 1, 0, -1);
    rd(1, 0, 0, -1, 0);
    rd(1, 'h3FC, 1, -1, 0);
    rand_b = 1'b1;
    repeat (40) begin
      len = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        for (int b = 0; b <= len; b++) begin wd[b] = $urandom; ws[b] = 4'($urandom); end
        lp = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len + 1)) : len;
        wr(IW'($urandom), int'($urandom_range(0, 255)) * 4, len, lp, 1, -1);
      end else rd(IW'($urandom), int'($urandom_range(0, 255)) * 4, len, -1, 1);
    end
    rand_b = 1'b0;
    for (int b = 0; b < 4; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
    wr(3, 'h40, 3, 3, 0, 2);
    rd(2, 'h40, 3, -1, 0);
    wr(1, 'h44, 0, 0, 0, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi4_slave_mem.md
AXI4_SLAVE_MEM -- requirements
Module: axi4_slave_mem

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 2, AXI ID width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte address width; data width fixed at 32.
REQ-003 SHALL have parameter MEM_WORDS, default 256, power-of-two depth of 32-bit storage.
REQ-004 clk_i  input  1  clock, all logic on rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 s_axi_awid  input  ID_WIDTH  write burst ID.
REQ-007 s_axi_awaddr  input  ADDR_WIDTH  write start byte address; bits [1:0] ignored.
REQ-008 s_axi_awlen  input  8  write beats minus one.
REQ-009 s_axi_awvalid  input  1  write address valid.
REQ-010 s_axi_awready  output  1  write address accepted.
REQ-011 s_axi_wdata  input  32  write data.
REQ-012 s_axi_wstrb  input  4  byte enables.
REQ-013 s_axi_wlast  input  1  final write beat marker.
REQ-014 s_axi_wvalid  input  1  write data valid.
REQ-015 s_axi_wready  output  1  write data accepted.
REQ-016 s_axi_bid  output  ID_WIDTH  response ID.
REQ-017 s_axi_bresp  output  2  write response, 00 OKAY, 10 SLVERR.
REQ-018 s_axi_bvalid  output  1  response valid.
REQ-019 s_axi_bready  input  1  response accepted.
REQ-020 s_axi_arid  input  ID_WIDTH  read burst ID.
REQ-021 s_axi_araddr  input  ADDR_WIDTH  read start byte address; bits [1:0] ignored.
REQ-022 s_axi_arlen  input  8  read beats minus one.
REQ-023 s_axi_arvalid  input  1  read address valid.
REQ-024 s_axi_arready  output  1  read address accepted.
REQ-025 s_axi_rid  output  ID_WIDTH  read data ID.
REQ-026 s_axi_rdata  output  32  read data.
REQ-027 s_axi_rresp  output  2  read response, 00 OKAY, 10 SLVERR.
REQ-028 s_axi_rlast  output  1  final read beat.
REQ-029 s_axi_rvalid  output  1  read data valid.
REQ-030 s_axi_rready  input  1  read data accepted.

Function
REQ-031 Bursts SHALL be INCR only, 4-byte beats; word pointer = addr[..:2], +1 per accepted beat, wrapping modulo MEM_WORDS.
REQ-032 Write FSM SHALL be W_IDLE (awready=1) -> on AW handshake capture id/ptr/len -> W_DATA (wready=1, awready=0).
REQ-033 W_DATA: each W handshake writes the bytes enabled by wstrb; after beat awlen+1 -> W_RESP.
REQ-034 W_RESP: bvalid=1, bid=captured id, bresp held stable until bready -> W_IDLE; awready returns the following cycle.
REQ-035 wlast absent on final beat or present on an earlier beat SHALL set bresp=10; the beat count still terminates the burst.
REQ-036 Read FSM SHALL be R_IDLE (arready=1) -> on AR handshake -> R_DATA; rvalid rises the cycle after handshake.
REQ-037 rdata/rresp/rlast/rid SHALL be registered and held stable while rvalid=1 and rready=0; next word loaded on each handshake.
REQ-038 rlast=1 only on beat arlen+1; its handshake -> R_IDLE, arready=1 next cycle.
REQ-039 Read and write FSMs SHALL be independent; a write to the word currently held in rdata is visible only on a later burst.

Reset
REQ-040 While rst_ni=0, all outputs SHALL be 0 and both FSMs IDLE; an in-flight burst is abandoned with no B/R completion; memory contents are not reset.

Configuration
REQ-041 With AXI_SLV_RANGE_CHK_EN defined: a beat whose unwrapped word index >= MEM_WORDS SHALL suppress its write and force bresp=10, or return rdata=0 with rresp=10; without it, pointers wrap per REQ-031 and range never produces SLVERR.

Verification
REQ-042 AW id=1 addr=0x10 len=3, W=1,2,3,4 strb=F, wlast on beat 4, bready=1 -> bvalid one cycle after beat 4, bid=1, bresp=00.
REQ-043 AR id=2 addr=0x10 len=3, rready=1 -> rdata 1,2,3,4 on consecutive cycles, rlast on beat 4 only, rid=2, rresp=00.
REQ-044 rready held low 3 cycles at beat 2 -> rdata=2, rlast=0 stable throughout; no beat skipped.
REQ-045 Word holds 0xFFFFFFFF, write 0xABCD1234 strb=0011 -> readback 0xFFFF1234.
REQ-046 MEM_WORDS=256, AW addr=0x3FC len=1 -> without macro, beat 2 writes word 0, bresp=00; with macro, word 0 unchanged, bresp=10.
REQ-047 rst_ni pulsed low after beat 2 of a len=3 write -> no bvalid; awready=1 the first cycle after release.
